// File: rtl/stack_ctrl_pkg.sv
// Shared encodings and default widths for the stack RAM sequencer.
package stack_ctrl_pkg;

    localparam int STK_ADDR_W = 8;
    localparam int STK_DATA_W = 32;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_PEEK = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_RADDR = 3'd2,
        ST_RWAIT = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/stack_ctrl.sv
// Stack RAM sequencer: push takes 2 cycles, pop/peek strobe 3 cycles after accept; one op in flight.
// req_ready is high only in IDLE; responses have no backpressure. STACK_GUARD_EN adds ovf/unf guarding.
module stack_ctrl
    import stack_ctrl_pkg::*;
#(
    parameter int ADDR_W = STK_ADDR_W,
    parameter int DATA_W = STK_DATA_W
) (
    input  logic              CLK,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W:0]   depth,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wen,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              err_clr,
    output logic              err_ovf,
    output logic              err_unf
);

    localparam logic [ADDR_W-1:0] SP_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [ADDR_W:0]   depth_q, depth_d;
    logic              empty_q, full_q;
    logic              ready_q, ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              ram_wen_q, ram_wen_d;
    logic              pop_q, pop_d;
    // noop marks a guarded op: no RAM write, no pointer move, zero read data
    logic              noop_q, noop_d;
`ifdef STACK_GUARD_EN
    logic              ovf_set, unf_set;
    logic              ovf_q, unf_q;
`endif

    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        depth_d     = depth_q;
        ready_d     = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_wen_d   = 1'b0;
        pop_d       = pop_q;
        noop_d      = noop_q;
`ifdef STACK_GUARD_EN
        ovf_set     = 1'b0;
        unf_set     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (req_valid && ready_q) begin
                    ready_d    = 1'b0;
                    state_d    = ST_RADDR;
                    ram_addr_d = sp_q - SP_ONE;
                    pop_d      = 1'b0;
`ifdef STACK_GUARD_EN
                    noop_d     = empty_q;
                    unf_set    = empty_q;
`else
                    noop_d     = 1'b0;
`endif
                    case (req_op)
                        OP_PUSH: begin
                            state_d     = ST_WRITE;
                            ram_addr_d  = sp_q;
                            ram_wdata_d = req_wdata;
`ifdef STACK_GUARD_EN
                            noop_d      = full_q;
                            ram_wen_d   = !full_q;
                            ovf_set     = full_q;
                            unf_set     = 1'b0;
`else
                            noop_d      = 1'b0;
                            ram_wen_d   = 1'b1;
`endif
                        end
                        OP_POP:  pop_d = 1'b1;
                        OP_PEEK: pop_d = 1'b0;
                        default: pop_d = 1'b0;
                    endcase
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                if (!noop_q) begin
                    sp_d = sp_q + SP_ONE;
                    if (depth_q != CNT_FULL) depth_d = depth_q + CNT_ONE;
                end
            end
            ST_RADDR: state_d = ST_RWAIT;
            ST_RWAIT: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = noop_q ? '0 : ram_rdata;
                if (pop_q && !noop_q) begin
                    sp_d = sp_q - SP_ONE;
                    if (depth_q != '0) depth_d = depth_q - CNT_ONE;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            sp_q        <= '0;
            depth_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_wen_q   <= 1'b0;
            pop_q       <= 1'b0;
            noop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            depth_q     <= depth_d;
            empty_q     <= (depth_d == '0);
            full_q      <= (depth_d == CNT_FULL);
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_wen_q   <= ram_wen_d;
            pop_q       <= pop_d;
            noop_q      <= noop_d;
        end
    end

`ifdef STACK_GUARD_EN
    // a new error in the same cycle as err_clr keeps the flag set
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_set | (ovf_q & ~err_clr);
            unf_q <= unf_set | (unf_q & ~err_clr);
        end
    end
    assign err_ovf = ovf_q;
    assign err_unf = unf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_ovf = 1'b0;
    assign err_unf = 1'b0;
`endif

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign depth     = depth_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_wen   = ram_wen_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: external RAM model plus an array/pointer reference stack, randomized ops.
module tb_stack_ctrl;
    import stack_ctrl_pkg::*;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 256;
`ifdef STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          CLK;
    logic          resetn;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [AW:0]   depth;
    logic          empty;
    logic          full;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_wen;
    logic [DW-1:0] ram_rdata;
    logic          err_clr;
    logic          err_ovf;
    logic          err_unf;

    stack_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .depth(depth), .empty(empty), .full(full),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wen(ram_wen), .ram_rdata(ram_rdata),
        .err_clr(err_clr), .err_ovf(err_ovf), .err_unf(err_unf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // single-port synchronous RAM with registered read data
    logic [DW-1:0] ram [DEPTH];
    always @(posedge CLK) begin
        if (ram_wen) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    int  ref_sp, ref_depth;
    bit  ref_ovf, ref_unf;
    int  last_acc, prev_len;
    bit  prev_held;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic chk_status();
        chk("depth", 64'(depth), 64'(ref_depth));
        chk("empty", 64'(empty), 64'(ref_depth == 0));
        chk("full", 64'(full), 64'(ref_depth == DEPTH));
        chk("err_ovf", 64'(err_ovf), 64'(ref_ovf));
        chk("err_unf", 64'(err_unf), 64'(ref_unf));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_ram_wen", 64'(ram_wen), 64'd0);
        chk("rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("rst_ram_wdata", 64'(ram_wdata), 64'd0);
        chk_status();
    endtask

    task automatic model_reset();
        ref_sp = 0; ref_depth = 0; ref_ovf = 1'b0; ref_unf = 1'b0; prev_held = 1'b0;
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        resetn = 1'b0;
        model_reset();
        @(negedge CLK);
        chk_reset_outputs();
        resetn = 1'b1;
        @(negedge CLK);
        chk("ready_after_rst", 64'(req_ready), 64'd1);
    endtask

    // Issue one op starting at a negedge; returns at the negedge where req_ready is back.
    task automatic do_op(input logic [1:0] op, input logic [DW-1:0] wd, input bit hold);
        int waitc;
        int sp_old;
        bit blocked;
        logic [DW-1:0] exp_d;
        req_valid = 1'b1; req_op = op; req_wdata = wd;
        waitc = 0;
        while (req_ready !== 1'b1 && waitc < 20) begin
            @(negedge CLK);
            waitc++;
        end
        if (req_ready !== 1'b1) begin
            chk("accept_timeout", 64'(waitc), 64'd0);
            req_valid = 1'b0;
            prev_held = 1'b0;
            return;
        end
        if (prev_held) chk("accept_gap", 64'(cyc - last_acc), 64'(prev_len));
        last_acc  = cyc;
        prev_held = hold;
        @(posedge CLK);
        @(negedge CLK);
        if (!hold) req_valid = 1'b0;
        chk("ready_drop", 64'(req_ready), 64'd0);
        sp_old = ref_sp;
        if (op == OP_PUSH) begin
            blocked = GUARD && (ref_depth == DEPTH);
            chk("push_wen", 64'(ram_wen), 64'(!blocked));
            chk("push_addr", 64'(ram_addr), 64'(sp_old));
            if (!blocked) begin
                chk("push_wdata", 64'(ram_wdata), 64'(wd));
                ref_mem[ref_sp] = wd;
                ref_sp = (ref_sp + 1) % DEPTH;
                if (ref_depth < DEPTH) ref_depth++;
            end else begin
                ref_ovf = 1'b1;
            end
            prev_len = 2;
            @(negedge CLK);
            chk("push_wen_off", 64'(ram_wen), 64'd0);
        end else begin
            blocked = GUARD && (ref_depth == 0);
            exp_d = blocked ? '0 : ref_mem[(sp_old + DEPTH - 1) % DEPTH];
            if (blocked) ref_unf = 1'b1;
            else if (op == OP_POP) begin
                ref_sp = (ref_sp + DEPTH - 1) % DEPTH;
                if (ref_depth > 0) ref_depth--;
            end
            prev_len = 4;
            for (int c = 1; c <= 4; c++) begin
                if (c > 1) @(negedge CLK);
                chk("rd_wen", 64'(ram_wen), 64'd0);
                chk("rsp_valid", 64'(rsp_valid), 64'(c == 3));
                if (c == 1 && !blocked) chk("rd_addr", 64'(ram_addr), 64'((sp_old + DEPTH - 1) % DEPTH));
                if (c == 3) chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_d));
            end
            chk("rsp_hold", 64'(rsp_rdata), 64'(exp_d));
        end
        chk("ready_back", 64'(req_ready), 64'd1);
        chk_status();
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge CLK);
        err_clr = 1'b0;
        ref_ovf = 1'b0;
        ref_unf = 1'b0;
        chk("clr_ovf", 64'(err_ovf), 64'd0);
        chk("clr_unf", 64'(err_unf), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int waitc;
        resetn = 1'b0; req_valid = 1'b0; req_op = OP_PUSH; req_wdata = '0; err_clr = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        model_reset();
        repeat (2) @(negedge CLK);
        chk_reset_outputs();
        resetn = 1'b1;
        @(negedge CLK);
        chk("ready_after_rst", 64'(req_ready), 64'd1);

        do_op(OP_PUSH, 32'h11, 1'b0);
        do_op(OP_PUSH, 32'h22, 1'b0);
        do_op(OP_PUSH, 32'h33, 1'b0);
        do_op(OP_POP,  32'h0,  1'b0);
        do_op(OP_PEEK, 32'h0,  1'b0);

        for (int i = 0; i < 10; i++)
            do_op((i % 2) ? OP_POP : OP_PUSH, 32'h100 + 32'(i), i != 9);

        do_reset();
        for (int i = 0; i < DEPTH; i++)
            do_op(OP_PUSH, 32'(i), i != DEPTH - 1);
        do_op(OP_PUSH, 32'hAA, 1'b0);
        do_op(OP_POP,  32'h0,  1'b0);

        do_reset();
        do_op(OP_POP, 32'h0, 1'b0);
        pulse_clr();
        do_op(OP_PUSH, 32'h77, 1'b0);

        // abort a POP while it waits on RAM data
        do_op(OP_PUSH, 32'h1234, 1'b0);
        req_valid = 1'b1; req_op = OP_POP;
        waitc = 0;
        while (req_ready !== 1'b1 && waitc < 20) begin
            @(negedge CLK);
            waitc++;
        end
        chk("abort_accept_wait", 64'(waitc), 64'd0);
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        @(negedge CLK);
        resetn = 1'b0;
        model_reset();
        #1;
        chk_reset_outputs();
        repeat (2) begin
            @(negedge CLK);
            chk("abort_no_rsp", 64'(rsp_valid), 64'd0);
        end
        resetn = 1'b1;
        @(negedge CLK);
        chk("ready_after_abort", 64'(req_ready), 64'd1);
        do_op(OP_PUSH, 32'h5, 1'b0);

        for (int i = 0; i < 300; i++)
            do_op(2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)));
        req_valid = 1'b0;
        @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
